// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: FSM states,
// opcodes, trap causes and the datapath mux / immediate select codes.
package rv_ctrl_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMRD,
      S_MEMWB,
      S_MEMWR,
      S_EXECR,
      S_EXECI,
      S_LUI,
      S_AUIPC,
      S_ALUWB,
      S_BRANCH,
      S_JAL,
      S_JALR,
      S_TRAP
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;

   localparam logic [1:0] CAUSE_NONE    = 2'd0;
   localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

   localparam logic [1:0] SRCA_PC    = 2'd0;
   localparam logic [1:0] SRCA_OLDPC = 2'd1;
   localparam logic [1:0] SRCA_RS1   = 2'd2;
   localparam logic [1:0] SRCA_ZERO  = 2'd3;

   localparam logic [1:0] SRCB_RS2  = 2'd0;
   localparam logic [1:0] SRCB_IMM  = 2'd1;
   localparam logic [1:0] SRCB_FOUR = 2'd2;

   localparam logic [1:0] ALUOP_ADD   = 2'd0;
   localparam logic [1:0] ALUOP_SUB   = 2'd1;
   localparam logic [1:0] ALUOP_FUNCT = 2'd2;

   localparam logic [2:0] IMM_I = 3'd0;
   localparam logic [2:0] IMM_S = 3'd1;
   localparam logic [2:0] IMM_B = 3'd2;
   localparam logic [2:0] IMM_U = 3'd3;
   localparam logic [2:0] IMM_J = 3'd4;

   localparam logic [1:0] RES_ALU = 2'd0;
   localparam logic [1:0] RES_MEM = 2'd1;
   localparam logic [1:0] RES_PC4 = 2'd3;

   // States that hold a memory request open
   function automatic logic is_mem_state(input state_t s);
      return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
   endfunction

endpackage

// File: rtl/mem_timeout.sv
// Memory wait-state counter; flags expiry on the last allowed wait cycle.
// Ports: clk, rst, clr (zero counter), pending (request open),
//        ready (request completes), expired (limit hit, no ready).
module mem_timeout #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic pending,
   input  logic ready,
   output logic expired
);

   localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

   logic [15:0] r_cnt;

   // A completed request also clears, so back-to-back memory
   // states start counting from zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (clr || ready) begin
         r_cnt <= '0;
      end else if (pending) begin
         r_cnt <= r_cnt + 16'd1;
      end
   end

   // r_cnt counts waits already spent; this cycle would be the
   // TIMEOUT_CYCLES-th. A same-cycle ready still wins.
   assign expired = pending && !ready && (r_cnt == LIMIT);

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core: sequences the shared
// datapath, handshakes with unified memory, traps on bad opcode/timeout.
// Ports: clk, rst, opcode, branch_taken, mem_ready in; memory request,
//        mux selects, write enables, retire, trap/trap_cause out.
module multicycle_ctrl
   import rv_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] opcode,
   input  logic       branch_taken,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_we,
   output logic       addr_src,
   output logic       ir_we,
   output logic       pc_we,
   output logic       pc_src,
   output logic       reg_we,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [2:0] imm_sel,
   output logic [1:0] result_src,
   output logic       retire,
   output logic       trap,
   output logic [1:0] trap_cause
);

   state_t     r_state;
   state_t     w_next;
   logic [1:0] r_cause;
   logic [1:0] w_cause;
   logic       w_clr;
   logic       w_expired;

   assign w_clr = !is_mem_state(r_state);

   mem_timeout #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk    (clk),
      .rst    (rst),
      .clr    (w_clr),
      .pending(mem_req),
      .ready  (mem_ready),
      .expired(w_expired)
   );

   always_comb begin
      w_next  = r_state;
      w_cause = CAUSE_NONE;
      case (r_state)
         S_IDLE:   w_next = S_FETCH;
         S_FETCH: begin
            if (mem_ready) begin
               w_next = S_DECODE;
            end else if (w_expired) begin
               w_next  = S_TRAP;
               w_cause = CAUSE_TIMEOUT;
            end
         end
         S_DECODE: begin
            case (opcode)
               OP_LOAD, OP_STORE: w_next = S_MEMADR;
               OP_REG:            w_next = S_EXECR;
               OP_IMM:            w_next = S_EXECI;
               OP_BRANCH:         w_next = S_BRANCH;
               OP_JAL:            w_next = S_JAL;
               OP_JALR:           w_next = S_JALR;
               OP_LUI:            w_next = S_LUI;
               OP_AUIPC:          w_next = S_AUIPC;
               OP_FENCE:          w_next = S_FETCH;
               default: begin
                  w_next  = S_TRAP;
                  w_cause = CAUSE_ILLEGAL;
               end
            endcase
         end
         S_MEMADR: begin
            w_next = (opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD, S_MEMWR: begin
            if (mem_ready) begin
               w_next = (r_state == S_MEMRD) ? S_MEMWB : S_FETCH;
            end else if (w_expired) begin
               w_next  = S_TRAP;
               w_cause = CAUSE_TIMEOUT;
            end
         end
         S_EXECR, S_EXECI,
         S_LUI, S_AUIPC:   w_next = S_ALUWB;
         S_MEMWB, S_ALUWB,
         S_BRANCH, S_JAL,
         S_JALR:           w_next = S_FETCH;
         S_TRAP:           w_next = S_TRAP;
         default:          w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cause <= CAUSE_NONE;
      end else begin
         r_state <= w_next;
         if ((w_next == S_TRAP) && (r_state != S_TRAP)) begin
            r_cause <= w_cause;
         end
      end
   end

   // Moore decode; only the FETCH and BRANCH write enables look at inputs
   always_comb begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      addr_src   = 1'b0;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      pc_src     = 1'b0;
      reg_we     = 1'b0;
      alu_src_a  = SRCA_PC;
      alu_src_b  = SRCB_RS2;
      alu_op     = ALUOP_ADD;
      imm_sel    = IMM_I;
      result_src = RES_ALU;
      retire     = 1'b0;
      trap       = 1'b0;
      case (r_state)
         S_FETCH: begin
            mem_req   = 1'b1;
            alu_src_b = SRCB_FOUR;
            ir_we     = mem_ready;
            pc_we     = mem_ready;
         end
         S_DECODE: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_IMM;
            imm_sel   = IMM_B;
            retire    = (opcode == OP_FENCE);
         end
         S_MEMADR: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            imm_sel   = (opcode == OP_STORE) ? IMM_S : IMM_I;
         end
         S_MEMRD: begin
            mem_req  = 1'b1;
            addr_src = 1'b1;
         end
         S_MEMWB: begin
            reg_we     = 1'b1;
            result_src = RES_MEM;
            retire     = 1'b1;
         end
         S_MEMWR: begin
            mem_req  = 1'b1;
            mem_we   = 1'b1;
            addr_src = 1'b1;
            retire   = mem_ready;
         end
         S_EXECR, S_EXECI: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = (r_state == S_EXECI) ? SRCB_IMM : SRCB_RS2;
            alu_op    = ALUOP_FUNCT;
         end
         S_LUI, S_AUIPC: begin
            alu_src_a = (r_state == S_AUIPC) ? SRCA_OLDPC : SRCA_ZERO;
            alu_src_b = SRCB_IMM;
            imm_sel   = IMM_U;
         end
         S_ALUWB: begin
            reg_we = 1'b1;
            retire = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a = SRCA_RS1;
            alu_op    = ALUOP_SUB;
            pc_src    = 1'b1;
            pc_we     = branch_taken;
            retire    = 1'b1;
         end
         S_JAL, S_JALR: begin
            alu_src_a  = (r_state == S_JALR) ? SRCA_RS1 : SRCA_OLDPC;
            alu_src_b  = SRCB_IMM;
            imm_sel    = (r_state == S_JALR) ? IMM_I : IMM_J;
            pc_we      = 1'b1;
            reg_we     = 1'b1;
            result_src = RES_PC4;
            retire     = 1'b1;
         end
         S_TRAP:  trap = 1'b1;
         default: ;
      endcase
   end

   assign trap_cause = r_cause;

endmodule
